r200_dmem_resp: RTL

- Data-memory responder for the r200 pipeline. It answers load/store requests issued by the MEM stage over a valid/ready request channel and a valid/ready response channel.
- Replaces the combinational data memory with a multi-cycle, back-pressured slave, so the pipeline can stall on memory.
- Implements RV32 byte, halfword and word access semantics using func3.

---
 rtl/r200_dmem_pkg.sv | 17 +
 rtl/r200_dmem_lane.sv | 93 +++++++++
 rtl/r200_dmem_resp.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/r200_dmem_pkg.sv
// r200_dmem_pkg
// Shared constants for the r200 data-memory responder:
//   - RV32 load/store func3 width codes (F3_*)
//   - responder FSM state encodings (DMEM_*)
package r200_dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] DMEM_IDLE = 2'd0;
  localparam logic [1:0] DMEM_BUSY = 2'd1;
  localparam logic [1:0] DMEM_RESP = 2'd2;

endpackage

// File: rtl/r200_dmem_lane.sv
// r200_dmem_lane
// Combinational byte-lane steering for one data-memory access.
// Ports:
//   we        in   1 = store, 0 = load
//   func3     in   RV32 width/sign code
//   addr_lo   in   byte offset within the word (addr[1:0])
//   wdata     in   right-aligned store data
//   rword     in   raw array word at the addressed index
//   be        out  per-byte write enable (all zero for loads and errors)
//   wdata_sh  out  store data replicated onto the enabled byte lanes
//   rdata_ext out  shifted and sign/zero-extended load data (0 for stores/errors)
//   err       out  illegal func3, or misaligned access when trapping is enabled
// Configuration macro: R200_DMEM_MISALIGN_TRAP_EN
//   defined   -> misaligned H/HU/W accesses report err
//   undefined -> low address bits are forced aligned for H/HU/W
module r200_dmem_lane
  import r200_dmem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        err
);

  logic        legal;
  logic [1:0]  eff_lo;
  logic [31:0] shifted;

  always_comb begin
    legal = 1'b0;
    case (func3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = ~we;
      default:          legal = 1'b0;
    endcase

`ifdef R200_DMEM_MISALIGN_TRAP_EN
    eff_lo = addr_lo;
    err    = ~legal
           | (((func3 == F3_H) || (func3 == F3_HU)) & addr_lo[0])
           | ((func3 == F3_W) & (addr_lo != 2'b00));
`else
    // Halfword and word accesses silently drop the low offset bits.
    if ((func3 == F3_H) || (func3 == F3_HU)) begin
      eff_lo = {addr_lo[1], 1'b0};
    end else if (func3 == F3_W) begin
      eff_lo = 2'b00;
    end else begin
      eff_lo = addr_lo;
    end
    err = ~legal;
`endif

    shifted   = rword >> {eff_lo, 3'b000};
    be        = 4'b0000;
    wdata_sh  = wdata;
    rdata_ext = 32'h0;

    if (!err) begin
      case (func3)
        F3_B: begin
          be        = 4'b0001 << eff_lo;
          wdata_sh  = {4{wdata[7:0]}};
          rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
        end
        F3_BU: rdata_ext = {24'h0, shifted[7:0]};
        F3_H: begin
          be        = 4'b0011 << eff_lo;
          wdata_sh  = {2{wdata[15:0]}};
          rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
        end
        F3_HU: rdata_ext = {16'h0, shifted[15:0]};
        F3_W: begin
          be        = 4'b1111;
          rdata_ext = shifted;
        end
        default: ;
      endcase
      // Stores return zero data; loads never write.
      if (we) begin
        rdata_ext = 32'h0;
      end else begin
        be = 4'b0000;
      end
    end
  end

endmodule

// File: rtl/r200_dmem_resp.sv
// r200_dmem_resp
// Multi-cycle, back-pressured data-memory responder for the r200 MEM stage.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_we, req_addr,
//   req_wdata, req_func3      request payload (store flag, byte address, data, width code)
//   resp_valid/resp_ready     response handshake
//   resp_rdata, resp_err      extended load data (0 for stores), error flag
// Parameters: DEPTH (words, power of two), LATENCY (accept-to-resp_valid cycles, >= 1).
// Configuration macro: R200_DMEM_MISALIGN_TRAP_EN (see r200_dmem_lane).
module r200_dmem_resp
  import r200_dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    func3_q, func3_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;

  logic [31:0]   mem_q [DEPTH];

  logic          commit;
  logic          cur_we;
  logic [AW+1:0] cur_addr;
  logic [31:0]   cur_wdata;
  logic [2:0]    cur_func3;
  logic [AW-1:0] cur_idx;
  logic [31:0]   rword;
  logic [3:0]    lane_be;
  logic [31:0]   lane_wdata;
  logic [31:0]   lane_rdata;
  logic          lane_err;

  // Upper address bits are intentionally ignored (accesses wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW+2];

  // With LATENCY==1 the commit happens on the accept edge itself, before the
  // request has been latched, so the lane must see the live request in IDLE.
  always_comb begin
    if (state_q == DMEM_IDLE) begin
      cur_we    = req_we;
      cur_addr  = req_addr[AW+1:0];
      cur_wdata = req_wdata;
      cur_func3 = req_func3;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_func3 = func3_q;
    end
  end

  assign cur_idx = cur_addr[AW+1:2];
  assign rword   = mem_q[cur_idx];

  r200_dmem_lane u_lane (
    .we        (cur_we),
    .func3     (cur_func3),
    .addr_lo   (cur_addr[1:0]),
    .wdata     (cur_wdata),
    .rword     (rword),
    .be        (lane_be),
    .wdata_sh  (lane_wdata),
    .rdata_ext (lane_rdata),
    .err       (lane_err)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    func3_d      = func3_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    commit       = 1'b0;

    case (state_q)
      DMEM_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr[AW+1:0];
          wdata_d = req_wdata;
          func3_d = req_func3;
          if (LATENCY == 1) begin
            commit  = 1'b1;
            state_d = DMEM_RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = DMEM_BUSY;
          end
        end
      end
      DMEM_BUSY: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = DMEM_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DMEM_RESP: begin
        if (resp_ready) begin
          state_d = DMEM_IDLE;
        end
      end
      default: state_d = DMEM_IDLE;
    endcase

    // Response payload is only ever loaded on the commit edge, so it stays
    // stable for the whole RESP phase.
    if (commit) begin
      resp_rdata_d = lane_rdata;
      resp_err_d   = lane_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= DMEM_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      func3_q      <= 3'b000;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      func3_q      <= func3_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Array is not reset; a reset coinciding with the commit edge drops the store.
  always_ff @(posedge clk) begin
    if (!rst && commit) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_be[b]) begin
          mem_q[cur_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
        end
      end
    end
  end

  assign req_ready  = (state_q == DMEM_IDLE);
  assign resp_valid = (state_q == DMEM_RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
